switch_allocator: RTL and testbench

- Separable-free, single-stage switch allocator for one router; shares the NUM_PORTS output ports among the NUM_PORTS input unit controllers.
- Each input presents a request plus a one-hot or multicast output-port mask (its registered route result).
- Grants are combinational, in the same cycle as the request, because input units pop on grant.
- Registers crossbar select one cycle later, aligned with the input units' registered ST data/control.
- Rotating priority plus per-input starvation counters guarantee forward progress for multicast.

---
 rtl/switch_allocator_pkg.sv | 18 +
 rtl/switch_allocator_rotate_scan.sv | 42 ++++
 rtl/switch_allocator.sv | 66 ++++++
 tb/tb_switch_allocator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/switch_allocator_pkg.sv
// switch_allocator_pkg: shared sizes, port indices and mask-slice helper for the switch allocator.
`define SA_MASK(vec, idx, n) vec[(idx)*(n) +: (n)]

package switch_allocator_pkg;
    localparam int NUM_PORTS    = 5;
    localparam int DIRECTION    = NUM_PORTS;
    localparam int STARVE_LIMIT = 8;
    localparam int CNT_WIDTH    = 4;
    localparam int PTR_WIDTH    = 3;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        N     = 3'd1,
        E     = 3'd2,
        S     = 3'd3,
        W     = 3'd4
    } port_e;
endpackage

// File: rtl/switch_allocator_rotate_scan.sv
// sa_rotate_scan: greedy all-or-nothing scan of candidate inputs starting at ptr,
// consuming outputs from the incoming free vector.
module sa_rotate_scan
    import switch_allocator_pkg::*;
#(
    parameter int NUM_PORTS = switch_allocator_pkg::NUM_PORTS,
    parameter int PTR_WIDTH = switch_allocator_pkg::PTR_WIDTH
) (
    input  logic [PTR_WIDTH-1:0]           ptr,
    input  logic [NUM_PORTS-1:0]           cand,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] route,
    input  logic [NUM_PORTS-1:0]           free_in,
    output logic [NUM_PORTS-1:0]           grant,
    output logic [NUM_PORTS-1:0]           free_out,
    output logic                           first_valid,
    output logic [PTR_WIDTH-1:0]           first_idx
);
    always_comb begin
        logic [PTR_WIDTH:0]   idx;
        logic [NUM_PORTS-1:0] mask;
        grant       = '0;
        free_out    = free_in;
        first_valid = 1'b0;
        first_idx   = '0;
        idx         = '0;
        mask        = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = {1'b0, ptr} + (PTR_WIDTH+1)'(k);
            idx = (idx >= (PTR_WIDTH+1)'(NUM_PORTS)) ? idx - (PTR_WIDTH+1)'(NUM_PORTS) : idx;
            mask = `SA_MASK(route, idx, NUM_PORTS);
            // whole mask must still be free, otherwise the input gets nothing
            if (cand[idx] && (mask & ~free_out) == '0) begin
                grant[idx] = 1'b1;
                free_out   = free_out & ~mask;
                if (!first_valid) begin
                    first_valid = 1'b1;
                    first_idx   = idx[PTR_WIDTH-1:0];
                end
            end
        end
    end
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: single-stage router switch allocator with rotating priority,
// starvation ageing and a registered crossbar select.
module switch_allocator
    import switch_allocator_pkg::*;
#(
    parameter int NUM_PORTS    = switch_allocator_pkg::NUM_PORTS,
    parameter int STARVE_LIMIT = switch_allocator_pkg::STARVE_LIMIT,
    parameter int CNT_WIDTH    = switch_allocator_pkg::CNT_WIDTH,
    parameter int PTR_WIDTH    = switch_allocator_pkg::PTR_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           sa_request,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] sa_route,
    output logic [NUM_PORTS-1:0]           sa_grant,
    output logic [NUM_PORTS*NUM_PORTS-1:0] xbar_sel,
    output logic [NUM_PORTS-1:0]           xbar_valid,
    output logic [PTR_WIDTH-1:0]           rr_ptr
);
    logic [NUM_PORTS-1:0]           eligible, urgent, grant_u, grant_n, grant, free_u, free_n;
    logic [NUM_PORTS*NUM_PORTS-1:0] sel_next;
    logic [CNT_WIDTH-1:0]           wait_cnt [NUM_PORTS];
    logic                           first_u, first_n;
    logic [PTR_WIDTH-1:0]           idx_u, idx_n, first_idx;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        assign eligible[i] = sa_request[i] && |`SA_MASK(sa_route, i, NUM_PORTS);
        assign urgent[i]   = eligible[i] && wait_cnt[i] >= CNT_WIDTH'(STARVE_LIMIT);
        for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
            assign sel_next[o*NUM_PORTS + i] = grant[i] & sa_route[i*NUM_PORTS + o];
        end
    end

    // urgent inputs claim outputs first; the leftovers go to the normal pass
    sa_rotate_scan #(.NUM_PORTS(NUM_PORTS), .PTR_WIDTH(PTR_WIDTH)) u_scan_urgent (
        .ptr(rr_ptr), .cand(urgent), .route(sa_route), .free_in({NUM_PORTS{1'b1}}),
        .grant(grant_u), .free_out(free_u), .first_valid(first_u), .first_idx(idx_u)
    );

    sa_rotate_scan #(.NUM_PORTS(NUM_PORTS), .PTR_WIDTH(PTR_WIDTH)) u_scan_normal (
        .ptr(rr_ptr), .cand(eligible & ~urgent), .route(sa_route), .free_in(free_u),
        .grant(grant_n), .free_out(free_n), .first_valid(first_n), .first_idx(idx_n)
    );

    assign grant     = grant_u | grant_n;
    assign sa_grant  = rst_n ? grant : '0;
    assign first_idx = first_u ? idx_u : idx_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            xbar_sel   <= '0;
            xbar_valid <= '0;
            for (int i = 0; i < NUM_PORTS; i++) wait_cnt[i] <= '0;
        end else begin
            xbar_sel   <= sel_next;
            xbar_valid <= ~free_n;
            if (first_u || first_n)
                rr_ptr <= (first_idx == PTR_WIDTH'(NUM_PORTS-1)) ? '0 : first_idx + 1'b1;
            for (int i = 0; i < NUM_PORTS; i++)
                wait_cnt[i] <= (eligible[i] && !grant[i])
                    ? ((wait_cnt[i] >= CNT_WIDTH'(STARVE_LIMIT)) ? CNT_WIDTH'(STARVE_LIMIT) : wait_cnt[i] + 1'b1)
                    : '0;
        end
    end
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed vector table, reset corners and modelled random
// traffic for the switch allocator, with a scoreboard for the crossbar stage.
module tb_switch_allocator;
    localparam int NP     = 5;
    localparam int STARVE = 8;

    typedef struct packed {
        logic [NP*NP-1:0] sel;
        logic [NP-1:0]    valid;
    } xb_t;

    typedef struct {
        logic [NP-1:0]    req;
        logic [NP*NP-1:0] route;
        logic [NP-1:0]    g;
        logic [2:0]       p;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NP-1:0]    sa_request = '0;
    logic [NP*NP-1:0] sa_route = '0;
    logic [NP-1:0]    sa_grant;
    logic [NP*NP-1:0] xbar_sel;
    logic [NP-1:0]    xbar_valid;
    logic [2:0]       rr_ptr;

    int  n_tests = 0;
    int  n_fail = 0;
    int  m_ptr = 0;
    int  m_cnt [NP];
    xb_t sb[$];

    switch_allocator dut (
        .clk(clk), .rst_n(rst_n), .sa_request(sa_request), .sa_route(sa_route),
        .sa_grant(sa_grant), .xbar_sel(xbar_sel), .xbar_valid(xbar_valid), .rr_ptr(rr_ptr)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [NP*NP-1:0] rt(input logic [4:0] m0, m1, m2, m3, m4);
        return {m4, m3, m2, m1, m0};
    endfunction

    function automatic logic [4:0] rand_mask();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 5'b0;
        if (r <= 5) return 5'(1 << $urandom_range(0, 4));
        if (r <= 8) return 5'($urandom);
        return 5'b11111;
    endfunction

    // two-pass greedy reference: urgent inputs first, then the rest, both from m_ptr
    task automatic model(input logic [NP-1:0] req, input logic [NP*NP-1:0] route,
                         output logic [NP-1:0] g, output int first);
        logic [NP-1:0] free, mk;
        int idx;
        free = '1;
        g = '0;
        first = -1;
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < NP; k++) begin
                idx = (m_ptr + k) % NP;
                mk = route[idx*NP +: NP];
                if (req[idx] && mk != 0 && ((m_cnt[idx] >= STARVE) == (p == 0)) && (mk & ~free) == 0) begin
                    g[idx] = 1'b1;
                    free = free & ~mk;
                    if (first < 0) first = idx;
                end
            end
    endtask

    task automatic step(input logic [NP-1:0] req, input logic [NP*NP-1:0] route, input logic hand,
                        input logic [NP-1:0] hg, input logic [2:0] hp,
                        output logic [NP-1:0] g, output logic [NP-1:0] ag);
        int first;
        logic [NP-1:0] eg;
        logic [2:0] ep;
        xb_t e;
        @(negedge clk);
        sa_request = req;
        sa_route = route;
        #1;
        model(req, route, g, first);
        if (first >= 0) m_ptr = (first + 1) % NP;
        for (int i = 0; i < NP; i++)
            m_cnt[i] = (req[i] && route[i*NP +: NP] != 0 && !g[i]) ? ((m_cnt[i] >= STARVE) ? STARVE : m_cnt[i] + 1) : 0;
        eg = hand ? hg : g;
        ep = hand ? hp : 3'(m_ptr);
        e = '0;
        for (int o = 0; o < NP; o++)
            for (int i = 0; i < NP; i++)
                e.sel[o*NP + i] = eg[i] & route[i*NP + o];
        for (int o = 0; o < NP; o++) e.valid[o] = |e.sel[o*NP +: NP];
        sb.push_back(e);
        ag = sa_grant;
        check("sa_grant", sa_grant, eg);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("xbar_sel", xbar_sel, e.sel);
        check("xbar_valid", xbar_valid, e.valid);
        check("rr_ptr", rr_ptr, ep);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sa_request = '0;
        sa_route = '0;
        sb.delete();
        m_ptr = 0;
        for (int i = 0; i < NP; i++) m_cnt[i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vec_t tbl [11];
        logic [NP-1:0] g, ag, creq;
        logic [NP*NP-1:0] croute;
        int run, worst;

        for (int i = 0; i < NP; i++) m_cnt[i] = 0;
        tbl[0]  = '{5'b01001, rt(5'b00001, 0, 0, 5'b00001, 0), 5'b00001, 3'd1};
        tbl[1]  = '{5'b01001, rt(5'b00001, 0, 0, 5'b00001, 0), 5'b01000, 3'd4};
        tbl[2]  = '{5'b01001, rt(5'b00001, 0, 0, 5'b00001, 0), 5'b00001, 3'd1};
        tbl[3]  = '{5'b01001, rt(5'b00001, 0, 0, 5'b00001, 0), 5'b01000, 3'd4};
        tbl[4]  = '{5'b00010, rt(0, 5'b00100, 0, 0, 0), 5'b00010, 3'd2};
        tbl[5]  = '{5'b00001, rt(5'b00001, 0, 0, 0, 0), 5'b00001, 3'd1};
        tbl[6]  = '{5'b00101, rt(5'b00110, 0, 5'b00100, 0, 0), 5'b00100, 3'd3};
        tbl[7]  = '{5'b11111, rt(5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001), 5'b11111, 3'd4};
        tbl[8]  = '{5'b00001, rt(0, 0, 0, 0, 0), 5'b00000, 3'd4};
        tbl[9]  = '{5'b00000, rt(0, 0, 0, 0, 0), 5'b00000, 3'd4};
        tbl[10] = '{5'b00011, rt(0, 5'b00001, 0, 0, 0), 5'b00010, 3'd2};

        // grant must stay low while reset is held, even with a live request
        sa_request = 5'b00010;
        sa_route = rt(0, 5'b00100, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("reset_grant", sa_grant, 5'b0);
        check("reset_valid", xbar_valid, 5'b0);
        check("reset_sel", xbar_sel, 25'b0);
        check("reset_ptr", rr_ptr, 3'd0);
        rst_n = 1'b1;
        sa_request = '0;
        sa_route = '0;

        for (int t = 0; t < 11; t++)
            step(tbl[t].req, tbl[t].route, 1'b1, tbl[t].g, tbl[t].p, g, ag);

        // reset asserted while a grant is live
        @(negedge clk);
        sa_request = 5'b00010;
        sa_route = rt(0, 5'b00100, 0, 0, 0);
        #1;
        check("midreset_pre_grant", sa_grant, 5'b00010);
        check("midreset_pre_valid", xbar_valid, 5'b00001);
        rst_n = 1'b0;
        #1;
        check("midreset_grant", sa_grant, 5'b0);
        check("midreset_valid", xbar_valid, 5'b0);
        check("midreset_sel", xbar_sel, 25'b0);
        check("midreset_ptr", rr_ptr, 3'd0);
        @(posedge clk);
        #1;
        check("midreset_hold_valid", xbar_valid, 5'b0);
        check("midreset_hold_ptr", rr_ptr, 3'd0);
        do_reset();

        // full-mask input 0 against unicast competitors on every other port
        run = 0;
        worst = 0;
        for (int c = 0; c < 24; c++) begin
            step(5'b11111, rt(5'b11111, 5'b00010, 5'b00100, 5'b01000, 5'b10000), 1'b0, '0, '0, g, ag);
            run = ag[0] ? 0 : run + 1;
            worst = (run > worst) ? run : worst;
        end
        check("starve_bound", 32'(worst <= STARVE), 32'd1);

        // input units hold a route until granted, so conflicting multicasts age up
        do_reset();
        for (int i = 0; i < NP; i++) begin
            creq[i] = 1'b1;
            croute[i*NP +: NP] = rand_mask();
        end
        for (int c = 0; c < 600; c++) begin
            step(creq, croute, 1'b0, '0, '0, g, ag);
            for (int i = 0; i < NP; i++)
                if (g[i] || $urandom_range(0, 15) == 0) begin
                    creq[i] = $urandom_range(0, 5) != 0;
                    croute[i*NP +: NP] = rand_mask();
                end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
